// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, on the MEM-stage data bus.
// Optional interrupt enable and interrupt output are compiled in when UART_TX_IRQ_EN is defined.
module mmio_uart_tx #(
  parameter int               WIDTH      = 32,
  parameter int               CLK_HZ     = 50000000,
  parameter int               BAUD       = 115200,
  parameter int               FIFO_DEPTH = 8,
  parameter logic [WIDTH-1:0] BASE_ADDR  = 32'h00000100
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [2:0]       MemLen,
  input  logic             MemWrite,
  input  logic             MemRead,
  output logic             hit,
  output logic [WIDTH-1:0] rdata,
  output logic             tx,
  output logic             irq
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_bit;
  logic [7:0]     r_shift;
  logic           r_tx;
  logic [7:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [AW:0]    r_count;
  logic           r_ovf;

  logic [WIDTH-1:0] w_offset;
  logic [1:0]       w_sel;
  logic             w_wr;
  logic             w_rd;
  logic             w_push_req;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_busy;
  logic             w_tick;
  logic [3:0]       w_fill;
  logic [WIDTH-1:0] w_status;
  logic [WIDTH-1:0] w_ctrl;
  logic             w_unused;

  assign w_offset   = addr - BASE_ADDR;
  assign hit        = (w_offset < WIDTH'(16));
  assign w_sel      = w_offset[3:2];
  assign w_wr       = hit && MemWrite;
  assign w_rd       = hit && MemRead;
  assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_busy     = (r_state != S_IDLE);
  assign w_tick     = (r_cnt == CW'(DIV - 1));
  assign w_push_req = w_wr && (w_sel == 2'd0);
  // Fullness is judged before this cycle's pop, so a store into a full FIFO is always dropped.
  assign w_push     = w_push_req && !w_full;
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_unused   = ^{MemLen, wdata[WIDTH-1:8]};
  assign tx         = r_tx;

  always_comb begin
    w_fill = (int'(r_count) > 15) ? 4'hF : 4'(r_count);
  end

  assign w_status = WIDTH'({w_fill, r_ovf, w_busy, w_empty, w_full});

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_tail] <= wdata[7:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (w_sel == 2'd1) && wdata[3]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_shift <= r_mem[r_head];
            r_tx    <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_TX_IRQ_EN
  logic r_ie;
  logic r_irq;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_wr && (w_sel == 2'd2)) r_ie <= wdata[0];
      r_irq <= r_ie && w_empty && !w_busy;
    end
  end

  assign irq    = r_irq;
  assign w_ctrl = WIDTH'(r_ie);
`else
  assign irq    = 1'b0;
  assign w_ctrl = '0;
`endif

  always_comb begin
    rdata = '0;
    if (w_rd) begin
      case (w_sel)
        2'd1:    rdata = w_status;
        2'd2:    rdata = w_ctrl;
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a cycle-timed frame model plus a line receiver, checked every cycle.
// DIV=10, FIFO_DEPTH=4, BASE_ADDR=0x100; IRQ expectations follow UART_TX_IRQ_EN.
module tb_mmio_uart_tx;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [2:0]  MemLen = 3'd2;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic        hit;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

`ifdef UART_TX_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  mmio_uart_tx #(
    .WIDTH(32), .CLK_HZ(1000), .BAUD(100), .FIFO_DEPTH(4), .BASE_ADDR(32'h00000100)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .addr(addr), .wdata(wdata), .MemLen(MemLen),
    .MemWrite(MemWrite), .MemRead(MemRead), .hit(hit), .rdata(rdata), .tx(tx), .irq(irq)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Model: a frame that starts at cycle s occupies the line for 100 cycles and the
  // transmitter for one more; the queue holds bytes not yet started.
  int          cyc = 0;
  logic [7:0]  q[$];
  bit          m_active = 0;
  int          m_start = 0;
  logic [7:0]  m_byte = 8'h0;
  bit          m_ovf = 0;
  bit          m_ie = 0;
  bit          m_busy = 0;
  bit          m_irq = 0;
  bit          m_tx = 1;

  task automatic model_reset();
    q.delete();
    m_active = 0; m_ovf = 0; m_ie = 0; m_busy = 0; m_irq = 0; m_tx = 1;
  endtask

  task automatic model_step();
    int  size0 = q.size();
    bit  busy0 = m_busy;
    bit  ie0 = m_ie;
    int  d;
    int  k;
    m_irq = IRQ_EN && ie0 && (size0 == 0) && !busy0;
    if (size0 > 0 && (!m_active || (cyc - m_start) >= 101)) begin
      m_byte = q.pop_front();
      m_start = cyc;
      m_active = 1;
    end
    if (MemWrite && addr == 32'h100) begin
      if (size0 < 4) q.push_back(wdata[7:0]);
      else m_ovf = 1;
    end
    if (MemWrite && addr == 32'h104 && wdata[3]) m_ovf = 0;
    if (IRQ_EN && MemWrite && addr == 32'h108) m_ie = wdata[0];
    d = cyc - m_start;
    m_busy = m_active && (d < 100);
    if (m_busy) begin
      k = d / 10;
      m_tx = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : m_byte[k-1];
    end else begin
      m_tx = 1'b1;
    end
  endtask

  function automatic logic [31:0] model_status();
    int n = q.size();
    logic [3:0] fill = (n > 15) ? 4'hF : 4'(n);
    return {24'h0, fill, m_ovf, m_busy, (n == 0), (n == 4)};
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
    if (!RST_N) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge RST_N);
    model_reset();
  end

  // Every-cycle comparison against the model.
  initial forever begin
    logic        e_hit;
    logic [31:0] e_rd;
    @(negedge CLK);
    e_hit = (addr >= 32'h100) && (addr <= 32'h10F);
    e_rd = 32'h0;
    if (e_hit && MemRead) begin
      if (addr == 32'h104) e_rd = model_status();
      else if (addr == 32'h108) e_rd = {31'h0, m_ie};
    end
    check("tx_line", tx, m_tx);
    check("irq_line", irq, m_irq);
    check("hit", hit, e_hit);
    check("rdata", rdata, e_rd);
  end

  // Line receiver: samples mid-bit after detecting a start bit.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         rx_err = 0;
  int         rx_st;
  logic [7:0] rx_b;

  initial forever begin
    @(negedge CLK);
    if (RST_N && tx === 1'b0) begin
      rx_st = cyc;
      repeat (4) @(negedge CLK);
      if (tx !== 1'b0) rx_err++;
      for (int i = 0; i < 8; i++) begin
        repeat (10) @(negedge CLK);
        rx_b[i] = tx;
      end
      repeat (10) @(negedge CLK);
      if (tx !== 1'b1) rx_err++;
      rx_q.push_back(rx_b);
      rx_t.push_back(rx_st);
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; MemWrite = 1'b1;
    @(posedge CLK); #1;
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    addr = a; MemRead = 1'b1;
    @(negedge CLK);
    check(name, rdata, exp);
    @(posedge CLK); #1;
    MemRead = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  logic [7:0] exp_rx [10] = '{8'h55, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'hA1, 8'hB2, 8'hC3, 8'h0F};
  logic       exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("reset_tx", tx, 1'b1);
    check("reset_irq", irq, 1'b0);
    RST_N = 1'b1;
    rd(32'h104, 32'h02, "reset_status");

    // Single byte 0x55: tx falls one edge after the store, then 10 mid-bit samples.
    wr(32'h100, 32'h55);
    check("tx_before_start", tx, 1'b1);
    idle(1);
    check("tx_start_edge", tx, 1'b0);
    idle(5);
    check("bit0", tx, exp_bits[0]);
    for (int i = 1; i < 10; i++) begin
      idle(10);
      check($sformatf("bit%0d", i), tx, exp_bits[i]);
    end
    idle(4);
    rd(32'h104, 32'h06, "status_stop_last");
    rd(32'h104, 32'h02, "status_frame_done");

    // Fill: one byte into the shifter, four queued, sixth store overflows.
    wr(32'h100, 32'h10);
    wr(32'h100, 32'h20);
    wr(32'h100, 32'h30);
    wr(32'h100, 32'h40);
    wr(32'h100, 32'h50);
    rd(32'h104, 32'h45, "status_full");
    wr(32'h100, 32'hEE);
    rd(32'h104, 32'h4D, "status_ovf");
    idle(600);
    rd(32'h104, 32'h0A, "status_drained_ovf");

    // W1C and unmapped accesses.
    wr(32'h104, 32'hF7);
    rd(32'h104, 32'h0A, "w1c_bit3_zero");
    wr(32'h104, 32'h08);
    rd(32'h104, 32'h02, "w1c_clear");
    wr(32'h10C, 32'hFF);
    rd(32'h10C, 32'h00, "read_0xC");
    rd(32'h100, 32'h00, "read_txdata");
    rd(32'h110, 32'h00, "read_outside");

    // Ordering with 1-cycle idle gap.
    wr(32'h100, 32'hA1);
    wr(32'h100, 32'hB2);
    wr(32'h100, 32'hC3);
    idle(320);

    // Interrupt on completion.
    wr(32'h108, 32'h1);
    rd(32'h108, {31'h0, IRQ_EN}, "ctrl_read");
    wr(32'h100, 32'h0F);
    idle(1);
    check("irq_during_frame", irq, 1'b0);
    idle(100);
    check("irq_at_stop_end", irq, 1'b0);
    idle(1);
    check("irq_after_stop", irq, IRQ_EN);
    idle(20);

    check("rx_count", rx_q.size(), 10);
    check("rx_framing", rx_err, 0);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("rx_byte%0d", i), (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_rx[i]);
    end
    for (int i = 2; i < 9; i++) begin
      if (i != 6) begin
        check($sformatf("frame_gap%0d", i),
              (i < rx_t.size()) ? (rx_t[i] - rx_t[i-1]) : -1, 101);
      end
    end

    // Reset mid-frame: line goes high at once, queued bytes discarded.
    wr(32'h100, 32'h33);
    wr(32'h100, 32'h44);
    idle(30);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_reset_tx", tx, 1'b1);
    rd(32'h104, 32'h02, "status_in_reset");
    check("irq_in_reset", irq, 1'b0);
    RST_N = 1'b1;
    idle(20);
    rd(32'h104, 32'h02, "status_after_reset");
    check("tx_after_reset", tx, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
